// File: rtl/fc_layer_sequencer.sv
// Serial loader, settle timer, parallel capture and result streamer
// wrapped around a clockless fully-connected neuron array.
module fc_layer_sequencer #(
  parameter int WIDTH      = 8,
  parameter int IN         = 400,
  parameter int N_OUT      = 80,
  parameter int OUT_W      = 2*WIDTH+9,
  parameter int SETTLE_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic [IN*WIDTH-1:0]          x_bus,
  input  logic [N_OUT*OUT_W-1:0]       z_bus,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [(N_OUT>1 ? $clog2(N_OUT) : 1)-1:0] out_idx,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int WI = (IN > 1) ? $clog2(IN) : 1;
  localparam int RI = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SETTLE,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t                 r_state;
  logic [WI-1:0]          r_wr;
  logic [RI-1:0]          r_rd;
  logic [7:0]             r_cnt;
  logic [IN*WIDTH-1:0]    r_x;
  logic [N_OUT*OUT_W-1:0] r_res;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [OUT_W-1:0]       r_out_data;
  logic [RI-1:0]          r_out_idx;
  logic                   r_busy;

  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_last_in;
  logic                   w_last_out;
  logic [RI-1:0]          w_rd_nxt;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_last_in  = (r_wr == WI'(IN-1));
  assign w_last_out = (r_rd == RI'(N_OUT-1));
  assign w_rd_nxt   = r_rd + 1'b1;

  assign in_ready   = r_in_ready;
  assign x_bus      = r_x;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_idx    = r_out_idx;
  assign busy       = r_busy;
  // Pulse lives in the accepting cycle itself, so it follows out_ready.
  assign frame_done = w_out_fire && w_last_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_wr        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_x         <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_x[r_wr*WIDTH +: WIDTH] <= in_data;
            if (w_last_in) begin
              r_wr       <= '0;
              r_cnt      <= 8'(SETTLE_CYC);
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_SETTLE;
            end else begin
              r_wr <= r_wr + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_CAPTURE: begin
          // First result goes straight to the output register.
          r_res       <= z_bus;
          r_rd        <= '0;
          r_out_data  <= z_bus[OUT_W-1:0];
          r_out_idx   <= '0;
          r_out_valid <= 1'b1;
          r_state     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_out_fire) begin
            if (w_last_out) begin
              r_rd        <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_LOAD;
            end else begin
              r_rd       <= w_rd_nxt;
              r_out_idx  <= w_rd_nxt;
              r_out_data <= r_res[w_rd_nxt*OUT_W +: OUT_W];
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with a summing stub array
// and a result scoreboard.
module tb_fc_layer_sequencer;

  localparam int W  = 8;
  localparam int IN = 4;
  localparam int NO = 2;
  localparam int OW = 2*W+9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0]  a_in_data;
  logic [IN*W-1:0] a_x;
  logic [NO*OW-1:0] a_z;
  logic [OW-1:0] a_out_data;
  logic [0:0]    a_out_idx;
  logic          a_busy, a_frame_done;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0]  b_in_data;
  logic [IN*W-1:0] b_x;
  logic [NO*OW-1:0] b_z;
  logic [OW-1:0] b_out_data;
  logic [0:0]    b_out_idx;
  logic          b_busy, b_frame_done;

  fc_layer_sequencer #(
    .WIDTH(W), .IN(IN), .N_OUT(NO), .OUT_W(OW), .SETTLE_CYC(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .x_bus(a_x), .z_bus(a_z),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_idx(a_out_idx),
    .busy(a_busy), .frame_done(a_frame_done)
  );

  fc_layer_sequencer #(
    .WIDTH(W), .IN(IN), .N_OUT(NO), .OUT_W(OW), .SETTLE_CYC(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .x_bus(b_x), .z_bus(b_z),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_idx(b_out_idx),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  // Stub array: z[j] = sum(x) + j
  function automatic logic [OW-1:0] vsum(input logic [IN*W-1:0] x);
    logic [OW-1:0] s;
    s = '0;
    for (int i = 0; i < IN; i++) s = s + OW'(x[i*W +: W]);
    return s;
  endfunction

  assign a_z = {vsum(a_x) + OW'(1), vsum(a_x)};
  assign b_z = {vsum(b_x) + OW'(1), vsum(b_x)};

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  typedef struct packed {
    logic [OW-1:0] d;
    logic [0:0]    idx;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int idx);
    sb.push_back(exp_t'{d: OW'(d), idx: 1'(idx)});
  endtask

  task automatic a_feed(input int d);
    int n;
    n = 0;
    a_in_valid = 1'b1;
    a_in_data  = 8'(d);
    @(negedge clk);
    while (!a_in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("a_feed_accept", 64'(a_in_ready), 64'(1));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_frame_done) fd_cnt++;
      if (a_out_valid && a_out_ready) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          m_e = sb.pop_front();
          chk("sb_out_data", 64'(a_out_data), 64'(m_e.d));
          chk("sb_out_idx", 64'(a_out_idx), 64'(m_e.idx));
          chk("sb_frame_done", 64'(a_frame_done), 64'(m_e.idx == 1'b1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fd0;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(a_in_ready), 64'(1));
    chk("rst_out_valid", 64'(a_out_valid), 64'(0));
    chk("rst_busy", 64'(a_busy), 64'(0));
    chk("rst_x_bus", 64'(a_x), 64'(0));
    chk("rst_out_data", 64'(a_out_data), 64'(0));
    chk("rst_out_idx", 64'(a_out_idx), 64'(0));
    chk("rst_frame_done", 64'(a_frame_done), 64'(0));
    chk("rst_b_in_ready", 64'(b_in_ready), 64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame with backpressure and upstream pressure
    push(10, 0);
    push(11, 1);
    for (int i = 1; i <= 4; i++) a_feed(i);
    a_in_valid = 1'b1;
    a_in_data  = 8'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("settle_in_ready", 64'(a_in_ready), 64'(0));
      chk("settle_out_valid", 64'(a_out_valid), 64'(0));
      chk("settle_busy", 64'(a_busy), 64'(1));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(a_out_valid), 64'(1));
      chk("hold_data", 64'(a_out_data), 64'(10));
      chk("hold_idx", 64'(a_out_idx), 64'(0));
      chk("hold_frame_done", 64'(a_frame_done), 64'(0));
      chk("hold_in_ready", 64'(a_in_ready), 64'(0));
      chk("hold_x_bus", 64'(a_x), 64'(32'h04030201));
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_frame_done && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("frame_done_seen", 64'(a_frame_done), 64'(1));
    chk("drain_x_bus", 64'(a_x), 64'(32'h04030201));
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    chk("reload_in_ready", 64'(a_in_ready), 64'(1));
    chk("reload_out_valid", 64'(a_out_valid), 64'(0));
    chk("reload_busy", 64'(a_busy), 64'(0));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("reload_elem0", 64'(a_x), 64'(32'h04030209));

    // Asynchronous reset in the middle of DRAIN
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) a_feed(i);
    n = 0;
    @(negedge clk);
    while (!a_out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("pre_rst_valid", 64'(a_out_valid), 64'(1));
    chk("pre_rst_data", 64'(a_out_data), 64'(15));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(a_in_ready), 64'(1));
    chk("arst_out_valid", 64'(a_out_valid), 64'(0));
    chk("arst_busy", 64'(a_busy), 64'(0));
    chk("arst_x_bus", 64'(a_x), 64'(0));
    chk("arst_out_data", 64'(a_out_data), 64'(0));
    chk("arst_out_idx", 64'(a_out_idx), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(a_in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(a_out_valid), 64'(0));
    @(posedge clk); #1;

    // Zero settle window with idle gaps between activations
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'(2*(i+1));
      @(negedge clk);
      chk("b_in_ready", 64'(b_in_ready), 64'(1));
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      @(negedge clk);
      chk("b_elem", 64'(b_x[i*W +: W]), 64'(2*(i+1)));
      if (i < 3) begin
        chk("b_next_empty", 64'(b_x[(i+1)*W +: W]), 64'(0));
        chk("b_gap_ready", 64'(b_in_ready), 64'(1));
        @(posedge clk); #1;
      end
    end
    chk("b_settle_valid", 64'(b_out_valid), 64'(0));
    chk("b_settle_busy", 64'(b_busy), 64'(1));
    chk("b_settle_ready", 64'(b_in_ready), 64'(0));
    @(negedge clk);
    chk("b_capture_valid", 64'(b_out_valid), 64'(0));
    @(negedge clk);
    chk("b_drain_valid", 64'(b_out_valid), 64'(1));
    chk("b_drain_data0", 64'(b_out_data), 64'(20));
    chk("b_drain_idx0", 64'(b_out_idx), 64'(0));
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("b_acc0_data", 64'(b_out_data), 64'(20));
    chk("b_acc0_fd", 64'(b_frame_done), 64'(0));
    @(negedge clk);
    chk("b_acc1_data", 64'(b_out_data), 64'(21));
    chk("b_acc1_idx", 64'(b_out_idx), 64'(1));
    chk("b_acc1_fd", 64'(b_frame_done), 64'(1));
    @(negedge clk);
    chk("b_done_valid", 64'(b_out_valid), 64'(0));
    chk("b_done_ready", 64'(b_in_ready), 64'(1));
    chk("b_done_fd", 64'(b_frame_done), 64'(0));
    @(posedge clk); #1;

    // Two back-to-back frames, free-running downstream
    fd0 = fd_cnt;
    a_out_ready = 1'b1;
    push(10, 0);
    push(11, 1);
    push(26, 0);
    push(27, 1);
    for (int i = 1; i <= 8; i++) a_feed(i);
    n = 0;
    @(negedge clk);
    while (sb.size() > 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_sb_drained", 64'(sb.size()), 64'(0));
    repeat (3) @(negedge clk);
    chk("b2b_frame_done_cnt", 64'(fd_cnt - fd0), 64'(2));
    chk("b2b_idle_valid", 64'(a_out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
